// File: rtl/mem_port_arbiter_pkg.sv
// Shared core package for the fetch/data memory port arbiter:
// FSM state type, starvation limit and the registered bus payload.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WSEL_W   = 4;
  localparam int unsigned STARVE_W = 2;

  localparam int unsigned MEM_ARB_STARVE_LIMIT = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IF_BUSY   = 2'd1,
    DM_BUSY   = 2'd2,
    DM_LOCKED = 2'd3
  } mem_arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [WSEL_W-1:0] wsel;
  } bus_xfer_t;

  // Saturating increment for the starvation counter.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and bus handshake signals of the memory port arbiter.
// master is the arbiter's view; slave is the core/memory view.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [WSEL_W-1:0] dm_wsel;
  logic              dm_lock;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [WSEL_W-1:0] bus_wsel;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wsel, dm_lock,
    input  bus_ack, bus_rdata,
    output if_valid, if_rdata, if_stall,
    output dm_valid, dm_rdata, dm_stall,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wsel
  );

  modport slave (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wsel, dm_lock,
    output bus_ack, bus_rdata,
    input  if_valid, if_rdata, if_stall,
    input  dm_valid, dm_rdata, dm_stall,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wsel
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and data accesses, with
// data priority, fetch anti-starvation and bus locking for atomics.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  mem_port_arbiter_if.master io
);

  mem_arb_state_t      state_q, state_d;
  logic                bus_req_q, bus_req_d;
  bus_xfer_t           xfer_q, xfer_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                grant_if, grant_dm;
  logic                ack;

  // An acknowledge only counts while a transfer is actually on the bus.
  assign ack = bus_req_q & io.bus_ack;

  always_comb begin
    state_d    = state_q;
    bus_req_d  = bus_req_q;
    xfer_d     = xfer_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    starve_d   = starve_q;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.dm_req &&
            !(io.if_req && (starve_q == STARVE_W'(MEM_ARB_STARVE_LIMIT)))) begin
          grant_dm = 1'b1;
        end else if (io.if_req) begin
          grant_if = 1'b1;
        end
      end
      IF_BUSY: begin
        if (ack) begin
          if_valid_d = 1'b1;
          if_rdata_d = io.bus_rdata;
          bus_req_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      DM_BUSY: begin
        if (ack) begin
          dm_valid_d = 1'b1;
          dm_rdata_d = io.bus_rdata;
          bus_req_d  = 1'b0;
          state_d    = io.dm_lock ? DM_LOCKED : IDLE;
        end
      end
      DM_LOCKED: begin
        // Bus stays reserved for the data side until the lock is released.
        if (io.dm_req) begin
          grant_dm = 1'b1;
        end else if (!io.dm_lock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_dm) begin
      state_d      = DM_BUSY;
      bus_req_d    = 1'b1;
      xfer_d.we    = io.dm_we;
      xfer_d.addr  = io.dm_addr;
      xfer_d.wdata = io.dm_wdata;
      xfer_d.wsel  = io.dm_wsel;
    end else if (grant_if) begin
      state_d      = IF_BUSY;
      bus_req_d    = 1'b1;
      xfer_d.we    = 1'b0;
      xfer_d.addr  = io.if_addr;
      xfer_d.wdata = '0;
      xfer_d.wsel  = '0;
    end

    if (!io.if_req || grant_if) begin
      starve_d = '0;
    end else if (grant_dm) begin
      starve_d = starve_inc(starve_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bus_req_q  <= 1'b0;
      xfer_q     <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      bus_req_q  <= bus_req_d;
      xfer_q     <= xfer_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      starve_q   <= starve_d;
    end
  end

  assign io.bus_req   = bus_req_q;
  assign io.bus_we    = xfer_q.we;
  assign io.bus_addr  = xfer_q.addr;
  assign io.bus_wdata = xfer_q.wdata;
  assign io.bus_wsel  = xfer_q.wsel;
  assign io.if_valid  = if_valid_q;
  assign io.if_rdata  = if_rdata_q;
  assign io.dm_valid  = dm_valid_q;
  assign io.dm_rdata  = dm_rdata_q;

  // Stalls are combinational so the pipeline can freeze in the request cycle.
  assign io.if_stall = io.if_req & ~if_valid_q;
  assign io.dm_stall = io.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam byte GI = 8'h49;
  localparam byte GD = 8'h44;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mem_port_arbiter_if arb_if();

  mem_port_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (arb_if)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  byte grant_log[$];

  // Model state: who owns the bus (0 none, 1 fetch, 2 data) and what it shows.
  int          m_owner  = 0;
  bit          m_locked = 1'b0;
  int          m_starve = 0;
  bit          m_req    = 1'b0;
  bit          m_we     = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic [3:0]  m_wsel   = '0;
  bit          m_ifv    = 1'b0;
  bit          m_dmv    = 1'b0;
  logic [31:0] m_ifr    = '0;
  logic [31:0] m_dmr    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    bit gi;
    bit gd;
    gi = 1'b0;
    gd = 1'b0;
    if (!reset_n) begin
      m_owner = 0; m_locked = 1'b0; m_starve = 0; m_req = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_wsel = '0;
      m_ifv = 1'b0; m_dmv = 1'b0; m_ifr = '0; m_dmr = '0;
    end else begin
      m_ifv = 1'b0;
      m_dmv = 1'b0;
      if (m_owner != 0) begin
        if (arb_if.bus_ack) begin
          if (m_owner == 1) begin
            m_ifv = 1'b1; m_ifr = arb_if.bus_rdata;
          end else begin
            m_dmv = 1'b1; m_dmr = arb_if.bus_rdata; m_locked = arb_if.dm_lock;
          end
          m_owner = 0;
          m_req   = 1'b0;
        end
      end else if (m_locked) begin
        if (arb_if.dm_req) gd = 1'b1;
        else if (!arb_if.dm_lock) m_locked = 1'b0;
      end else begin
        if (arb_if.dm_req && (!arb_if.if_req || m_starve != MEM_ARB_STARVE_LIMIT)) gd = 1'b1;
        else if (arb_if.if_req) gi = 1'b1;
      end
      if (!arb_if.if_req || gi) m_starve = 0;
      else if (gd && m_starve < 3) m_starve = m_starve + 1;
      if (gd) begin
        m_owner = 2; m_req = 1'b1; m_we = arb_if.dm_we; m_addr = arb_if.dm_addr;
        m_wdata = arb_if.dm_wdata; m_wsel = arb_if.dm_wsel;
      end else if (gi) begin
        m_owner = 1; m_req = 1'b1; m_we = 1'b0; m_addr = arb_if.if_addr;
        m_wdata = '0; m_wsel = '0;
      end
    end
  end

  // Every-cycle comparison against the model, plus a log of completed transfers.
  always @(negedge clk) begin
    chk("bus_req",   32'(arb_if.bus_req),   32'(m_req));
    chk("bus_we",    32'(arb_if.bus_we),    32'(m_we));
    chk("bus_addr",  arb_if.bus_addr,       m_addr);
    chk("bus_wdata", arb_if.bus_wdata,      m_wdata);
    chk("bus_wsel",  32'(arb_if.bus_wsel),  32'(m_wsel));
    chk("if_valid",  32'(arb_if.if_valid),  32'(m_ifv));
    chk("if_rdata",  arb_if.if_rdata,       m_ifr);
    chk("dm_valid",  32'(arb_if.dm_valid),  32'(m_dmv));
    chk("dm_rdata",  arb_if.dm_rdata,       m_dmr);
    chk("if_stall",  32'(arb_if.if_stall),  32'(arb_if.if_req & ~m_ifv));
    chk("dm_stall",  32'(arb_if.dm_stall),  32'(arb_if.dm_req & ~m_dmv));
    if (reset_n && arb_if.if_valid) grant_log.push_back(GI);
    if (reset_n && arb_if.dm_valid) grant_log.push_back(GD);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_log(input string name, input byte exp[$]);
    chk({name, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < grant_log.size()) chk({name, "_order"}, 32'(grant_log[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte exp_q[$];
    arb_if.if_req = 1'b0; arb_if.if_addr = '0;
    arb_if.dm_req = 1'b0; arb_if.dm_we = 1'b0; arb_if.dm_addr = '0;
    arb_if.dm_wdata = '0; arb_if.dm_wsel = '0; arb_if.dm_lock = 1'b0;
    arb_if.bus_ack = 1'b0; arb_if.bus_rdata = '0;
    reset_n = 1'b0;
    repeat (3) step();
    chk("rst_bus_req",  32'(arb_if.bus_req), 32'd0);
    chk("rst_bus_addr", arb_if.bus_addr, 32'd0);
    chk("rst_if_valid", 32'(arb_if.if_valid), 32'd0);
    chk("rst_dm_rdata", arb_if.dm_rdata, 32'd0);
    reset_n = 1'b1;

    // Single fetch, first edge after reset, acked on first bus_req cycle.
    arb_if.if_req = 1'b1; arb_if.if_addr = 32'h0000_0100;
    step();
    chk("s1_bus_req",  32'(arb_if.bus_req), 32'd1);
    chk("s1_bus_addr", arb_if.bus_addr, 32'h0000_0100);
    chk("s1_bus_we",   32'(arb_if.bus_we), 32'd0);
    arb_if.if_req = 1'b0; arb_if.bus_ack = 1'b1; arb_if.bus_rdata = 32'hDEAD_BEEF;
    step();
    chk("s1_if_valid", 32'(arb_if.if_valid), 32'd1);
    chk("s1_if_rdata", arb_if.if_rdata, 32'hDEAD_BEEF);
    chk("s1_bus_drop", 32'(arb_if.bus_req), 32'd0);
    arb_if.bus_ack = 1'b0;
    step();
    chk("s1_pulse_end", 32'(arb_if.if_valid), 32'd0);

    // Both requesters held, ack always high: starvation limit interleaves fetches.
    grant_log.delete();
    arb_if.if_req = 1'b1; arb_if.if_addr = 32'h0000_0400;
    arb_if.dm_req = 1'b1; arb_if.dm_addr = 32'h0000_0800;
    arb_if.bus_ack = 1'b1; arb_if.bus_rdata = 32'h0BAD_F00D;
    repeat (12) step();
    arb_if.if_req = 1'b0; arb_if.dm_req = 1'b0;
    step(); step();
    exp_q = '{GD, GD, GI, GD, GD, GI};
    check_log("s2", exp_q);

    // Locked pair of data transfers holds off a pending fetch.
    grant_log.delete();
    arb_if.if_req = 1'b1; arb_if.if_addr = 32'h0000_0500;
    arb_if.dm_req = 1'b1; arb_if.dm_lock = 1'b1; arb_if.dm_addr = 32'h0000_0900;
    step(); step(); step();
    arb_if.dm_req = 1'b0;
    step();
    repeat (3) begin
      step();
      chk("s3_no_fetch", 32'(arb_if.bus_req), 32'd0);
      chk("s3_if_stall", 32'(arb_if.if_stall), 32'd1);
    end
    arb_if.dm_lock = 1'b0;
    step();
    chk("s3_idle_gap", 32'(arb_if.bus_req), 32'd0);
    step();
    chk("s3_fetch_req",  32'(arb_if.bus_req), 32'd1);
    chk("s3_fetch_addr", arb_if.bus_addr, 32'h0000_0500);
    arb_if.if_req = 1'b0;
    step();
    arb_if.bus_ack = 1'b0;
    step(); step();
    exp_q = '{GD, GD, GI};
    check_log("s3", exp_q);

    // Store with delayed ack: bus payload frozen, data side stalled.
    arb_if.dm_req = 1'b1; arb_if.dm_we = 1'b1; arb_if.dm_addr = 32'h0000_0200;
    arb_if.dm_wdata = 32'hA5A5_1234; arb_if.dm_wsel = 4'b0011;
    step();
    arb_if.dm_we = 1'b0; arb_if.dm_wdata = 32'h0; arb_if.dm_wsel = 4'b0; arb_if.dm_addr = 32'h0;
    repeat (5) begin
      chk("s4_bus_req",   32'(arb_if.bus_req), 32'd1);
      chk("s4_bus_we",    32'(arb_if.bus_we), 32'd1);
      chk("s4_bus_addr",  arb_if.bus_addr, 32'h0000_0200);
      chk("s4_bus_wdata", arb_if.bus_wdata, 32'hA5A5_1234);
      chk("s4_bus_wsel",  32'(arb_if.bus_wsel), 32'h3);
      chk("s4_dm_stall",  32'(arb_if.dm_stall), 32'd1);
      step();
    end
    arb_if.bus_ack = 1'b1;
    step();
    chk("s4_dm_valid", 32'(arb_if.dm_valid), 32'd1);
    chk("s4_dm_stall_clr", 32'(arb_if.dm_stall), 32'd0);
    arb_if.dm_req = 1'b0; arb_if.bus_ack = 1'b0;
    step();
    chk("s4_pulse_end", 32'(arb_if.dm_valid), 32'd0);

    // Reset in the middle of a data transfer.
    grant_log.delete();
    arb_if.dm_req = 1'b1; arb_if.dm_addr = 32'h0000_0300;
    step();
    chk("s5_bus_req", 32'(arb_if.bus_req), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk("s5_async_drop", 32'(arb_if.bus_req), 32'd0);
    arb_if.dm_req = 1'b0;
    step();
    reset_n = 1'b1;
    step(); step();
    chk("s5_no_valid", 32'(grant_log.size()), 32'd0);
    arb_if.if_req = 1'b1; arb_if.if_addr = 32'h0000_0600;
    step();
    chk("s5_idle_grant", 32'(arb_if.bus_req), 32'd1);
    chk("s5_grant_addr", arb_if.bus_addr, 32'h0000_0600);
    arb_if.if_req = 1'b0; arb_if.bus_ack = 1'b1; arb_if.bus_rdata = 32'hCAFE_0001;
    step();
    arb_if.bus_ack = 1'b0;
    step();

    // Spurious ack while idle.
    grant_log.delete();
    arb_if.bus_ack = 1'b1; arb_if.bus_rdata = 32'h1234_5678;
    repeat (3) begin
      step();
      chk("s6_no_req", 32'(arb_if.bus_req), 32'd0);
    end
    arb_if.bus_ack = 1'b0;
    step();
    chk("s6_no_valid", 32'(grant_log.size()), 32'd0);
    chk("s6_if_rdata", arb_if.if_rdata, 32'hCAFE_0001);
    chk("s6_dm_rdata", arb_if.dm_rdata, 32'h0);
    arb_if.dm_req = 1'b1; arb_if.dm_addr = 32'h0000_0700;
    step();
    chk("s6_grant", 32'(arb_if.bus_req), 32'd1);
    arb_if.dm_req = 1'b0; arb_if.bus_ack = 1'b1;
    step();
    chk("s6_dm_valid", 32'(arb_if.dm_valid), 32'd1);
    chk("s6_dm_rdata_new", arb_if.dm_rdata, 32'h1234_5678);
    arb_if.bus_ack = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL use a single clock; reset is asynchronous and active-low.
REQ-002 SHALL have these clock and reset ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
REQ-003 SHALL have these fetch-side ports:
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_valid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  32  fetch data
- if_stall  out  1  fetch waiting
REQ-004 SHALL have these data-side ports:
- dm_req  in  1  load/store/atomic request
- dm_we  in  1  write
- dm_addr  in  32  byte address
- dm_wdata  in  32  write data
- dm_wsel  in  4  byte enables
- dm_lock  in  1  hold bus for atomic read-modify-write
- dm_valid  out  1  data response valid, one-cycle pulse
- dm_rdata  out  32  load data
- dm_stall  out  1  data waiting
REQ-005 SHALL have these bus-side ports:
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_wsel  out  4  bus byte enables
- bus_ack  in  1  transfer complete
- bus_rdata  in  32  bus read data

Function
REQ-006 SHALL implement an FSM with states IDLE, IF_BUSY, DM_BUSY, DM_LOCKED.
REQ-007 IDLE SHALL grant as follows:
- dm_req only -> DM_BUSY.
- if_req only -> IF_BUSY.
- Both -> DM_BUSY, unless the starvation counter equals STARVE_LIMIT (2), in which case -> IF_BUSY.
REQ-008 On grant, the requester's address, we, wdata and wsel SHALL be registered onto bus_* and bus_req asserted in the next cycle. bus_we and bus_wsel SHALL be 0 for a fetch.
REQ-009 bus_* outputs SHALL stay stable while bus_req=1 and bus_ack=0.
REQ-010 On bus_ack:
- bus_req SHALL drop in the next cycle.
- bus_rdata SHALL be registered into if_rdata or dm_rdata.
- The matching if_valid or dm_valid SHALL pulse for exactly one cycle, in the cycle after bus_ack.
REQ-011 Minimum request-to-valid latency SHALL be 2 cycles, with bus_ack arriving in the first cycle bus_req is high.
REQ-012 Stall outputs SHALL be combinational:
- if_stall = if_req & ~if_valid
- dm_stall = dm_req & ~dm_valid
REQ-013 The starvation counter (2 bits, saturating) SHALL behave as follows:
- Increment on each DM grant while if_req=1.
- Clear on each IF grant.
- Clear in any cycle with if_req=0.
REQ-014 DM_BUSY with dm_lock=1 at bus_ack SHALL go to DM_LOCKED rather than IDLE.
REQ-015 DM_LOCKED SHALL behave as follows:
- Only data requests are granted; if_req is ignored and if_stall stays high.
- A new dm_req is issued directly, without passing through IDLE.
- dm_lock=0 with no dm_req pending -> IDLE.
REQ-016 Once issued, a transfer SHALL NOT be aborted by requester deassertion; its response SHALL still pulse valid.
REQ-017 bus_ack arriving while bus_req=0 SHALL be ignored.
REQ-018 A fetch and a data transfer SHALL never be in flight simultaneously.

Reset
REQ-019 While reset_n=0, all of the following SHALL be forced asynchronously:
- FSM -> IDLE
- bus_req, bus_we, if_valid, dm_valid -> 0
- bus_addr, bus_wdata, bus_wsel, if_rdata, dm_rdata -> 0
- starvation counter -> 0
REQ-020 Reset mid-transfer SHALL drop bus_req immediately. No valid pulse SHALL be produced for the lost transfer.
REQ-021 The first grant SHALL be possible in the first clk edge after reset_n rises.

Structure
REQ-022 The mem_arb_state_t enum and the constant MEM_ARB_STARVE_LIMIT=2 SHALL reside in the shared core package.
REQ-023 The block SHALL be a single module with no sub-modules. It SHALL be instantiated beside control_unit; if_stall and dm_stall feed the pipeline stall input.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Only if_req=1, addr 0x100, bus_ack on first bus_req cycle -> bus_addr=0x100, if_valid one cycle later with if_rdata = bus_rdata (0xDEADBEEF).
- if_req and dm_req both held, bus_ack always 1 -> grant order DM, DM, IF, DM, DM, IF.
- dm_lock=1 with two back-to-back data transfers while if_req=1 -> no fetch issued until dm_lock=0 and back in IDLE; fetch issues next.
- Store with wsel=4'b0011 and bus_ack delayed 5 cycles -> bus_* stable for all 5 cycles; dm_stall high until dm_valid.
- reset_n low during DM_BUSY -> bus_req=0 in the same cycle, no dm_valid, FSM in IDLE.
- Spurious bus_ack in IDLE -> no valid pulse, no state change.
